// File: rtl/syn_tle_drain.sv
// ============================================================================
// Module   : syn_tle_drain
// Purpose  : Buffers one MMA result tile and streams it out one row per beat.
// Option   : SYN_TLE_DRAIN_DOUBLE_BUF_EN selects a two-slot ping-pong buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syn_tle_drain #(
  parameter int M     = 8,
  parameter int N     = 4,
  parameter int P     = 8,
  parameter int RIDXW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic signed [M-1:0][N-1:0][4*P-1:0]    D_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic signed [N-1:0][4*P-1:0]           row_o,
  output logic        [RIDXW-1:0]                row_idx_o,
  output logic                                   last_o,
  output logic                                   valid_o,
  input  logic                                   ready_i
);

  typedef logic [M-1:0][N-1:0][4*P-1:0] tile_t;
  typedef logic [N-1:0][4*P-1:0]        row_t;

  localparam logic [RIDXW-1:0] LAST_ROW = RIDXW'(M - 1);

  logic [RIDXW-1:0] row_cnt_q, row_cnt_d;
  logic             accept, beat, last_row;
  row_t             rd_row;

  assign accept    = valid_i && ready_o;
  assign beat      = valid_o && ready_i;
  assign last_row  = (row_cnt_q == LAST_ROW);
  assign row_o     = valid_o ? rd_row : '0;
  assign row_idx_o = row_cnt_q;
  assign last_o    = valid_o && last_row;

`ifdef SYN_TLE_DRAIN_DOUBLE_BUF_EN
  tile_t      slot_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  assign rd_row = slot_q[rd_ptr_q][row_cnt_q];

  always_comb begin
    ready_o   = (count_q != 2'd2);
    valid_o   = (count_q != 2'd0);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_cnt_d = row_cnt_q;
    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (beat) begin
      if (last_row) begin
        rd_ptr_d  = ~rd_ptr_q;
        row_cnt_d = '0;
      end else begin
        row_cnt_d = row_cnt_q + RIDXW'(1);
      end
    end
    // Accept and last beat in the same cycle cancel out.
    count_d = count_q + 2'(accept) - 2'(beat && last_row);
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      row_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_q[wr_ptr_q] <= D_i;
    end
  end
`else
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e state_q, state_d;
  tile_t  tile_q;

  assign rd_row = tile_q[row_cnt_q];

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d   = S_DRAIN;
          row_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        valid_o = 1'b1;
        if (ready_i) begin
          if (last_row) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + RIDXW'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        row_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Storage is left unreset: contents only matter after a capture.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tile_q <= D_i;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_tle_drain.sv
// ============================================================================
// Module   : tb_syn_tle_drain
// Purpose  : Table-driven directed bench for syn_tle_drain (M=8, N=4, P=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_syn_tle_drain;

  localparam int M = 8;
  localparam int N = 4;
  localparam int P = 8;
  localparam int RIDXW = 3;

  logic                         clk;
  logic                         rst;
  logic [M-1:0][N-1:0][4*P-1:0] d;
  logic                         vi;
  logic                         ro;
  logic [N-1:0][4*P-1:0]        row;
  logic [RIDXW-1:0]             ridx;
  logic                         last;
  logic                         vo;
  logic                         ri;

  syn_tle_drain #(.M(M), .N(N), .P(P), .RIDXW(RIDXW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst),
    .D_i       (d),
    .valid_i   (vi),
    .ready_o   (ro),
    .row_o     (row),
    .row_idx_o (ridx),
    .last_o    (last),
    .valid_o   (vo),
    .ready_i   (ri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pat: 0 ramp 16r+c, 1 all 7, 2 all 5, 3 alternating signed extremes
  typedef struct {
    bit rs;
    bit vi;
    bit ri;
    int pat;
    bit evo;
    bit ero;
    int eidx;
    bit elast;
    int epat;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] elem(int pat, int r, int c);
    case (pat)
      0:       return 32'(16 * r + c);
      1:       return 32'd7;
      2:       return 32'd5;
      default: return ((r + c) % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  endfunction

  function automatic void add(bit rs_, bit vi_, bit ri_, int pat_, bit evo_, bit ero_,
                              int eidx_, bit elast_, int epat_);
    vec_t v;
    v.rs = rs_; v.vi = vi_; v.ri = ri_; v.pat = pat_;
    v.evo = evo_; v.ero = ero_; v.eidx = eidx_; v.elast = elast_; v.epat = epat_;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [127:0] act, logic [127:0] exp);
    if (act !== exp) begin
      $display("FAIL %s (vector %0d): got %h expected %h", nm, idx, act, exp);
      n_err++;
    end
  endtask

  initial begin
    logic [N-1:0][4*P-1:0] erow;
    rst = 1'b0; vi = 1'b0; ri = 1'b0; d = '0;

    // Reset state
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Basic drain of the ramp tile
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int r = 0; r < M; r++) add(0, 0, 1, 0, 1, 0, r, r == M - 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);

    // Backpressure on row 2 with signed-extreme data
    add(0, 1, 1, 3, 0, 1, 0, 0, 0);
    add(0, 0, 1, 3, 1, 0, 0, 0, 3);
    add(0, 0, 1, 3, 1, 0, 1, 0, 3);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 3, 1, 0, 2, 0, 3);
    for (int r = 2; r < M; r++) add(0, 0, 1, 3, 1, 0, r, r == M - 1, 3);
    add(0, 0, 1, 3, 0, 1, 0, 0, 0);

`ifndef SYN_TLE_DRAIN_DOUBLE_BUF_EN
    // Tile offered while busy must be ignored
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1, 0, 0);
    for (int r = 2; r < M; r++) add(0, 0, 1, 1, 1, 0, r, r == M - 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);

    // Back-to-back: second tile waits for the single slot
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int r = 0; r < M; r++) add(0, 1, 1, 3, 1, 0, r, r == M - 1, 0);
    add(0, 1, 1, 3, 0, 1, 0, 0, 0);
    for (int r = 0; r < M; r++) add(0, 0, 1, 0, 1, 0, r, r == M - 1, 3);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
`else
    // Back-to-back: second tile lands in the spare slot immediately
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 3, 1, 1, 0, 0, 0);
    for (int r = 1; r < M; r++) add(0, 1, 1, 3, 1, 0, r, r == M - 1, 0);
    for (int r = 0; r < M; r++) add(0, 0, 1, 0, 1, 1, r, r == M - 1, 3);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
`endif

    // Reset while row 3 is on the output, then a fresh all-5 tile
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int r = 0; r < 3; r++) add(0, 0, 1, 0, 1, 0, r, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 2, 0, 1, 0, 0, 0);
    for (int r = 0; r < M; r++) add(0, 0, 1, 2, 1, 0, r, r == M - 1, 2);
    add(0, 0, 1, 2, 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      vi = tbl[i].vi;
      ri = tbl[i].ri;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          d[r][c] = elem(tbl[i].pat, r, c);
      if (tbl[i].rs) rst = 1'b1;
      #1;
      for (int c = 0; c < N; c++)
        erow[c] = tbl[i].evo ? elem(tbl[i].epat, tbl[i].eidx, c) : 32'd0;
      n_vec++;
      chk("valid_o",   i, 128'(vo),   128'(tbl[i].evo));
      chk("ready_o",   i, 128'(ro),   128'(tbl[i].ero));
      chk("row_idx_o", i, 128'(ridx), 128'(tbl[i].eidx));
      chk("last_o",    i, 128'(last), 128'(tbl[i].elast));
      chk("row_o",     i, 128'(row),  128'(erow));
      if (tbl[i].rs) rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/syn_tle_drain.md
Name: syn_tle_drain

Overview:
- Downstream neighbour of the elastic MMA tile engine.
- Consumes one full result tile D[M][N] per valid/ready handshake and buffers it.
- Streams the tile out one row (N accumulators) per beat on a narrow valid/ready port, with row index and last-row flag.
- Decouples the wide tile output from the narrow writeback/memory interface.

Parameters:
M, 8, tile rows; also the number of output beats per tile
N, 4, tile columns; number of elements per output beat
P, 8, operand precision; each accumulator is 4*P bits wide
RIDXW, $clog2(M) (min 1), width of row_idx_o

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous, active-high reset
D_i  input  signed [4*P-1:0] [M][N]  result tile from the MMA stage
valid_i  input  1  D_i is valid
ready_o  output  1  block can accept a tile this cycle
row_o  output  signed [4*P-1:0] [N]  current output row, equal to tile[row_idx_o][0..N-1]
row_idx_o  output  RIDXW  index of the row on row_o
last_o  output  1  row_o is row M-1 of the tile
valid_o  output  1  row_o/row_idx_o/last_o are valid
ready_i  input  1  downstream accepts the row this cycle

Behaviour:
- Reset (async, rst_ni=1): state=IDLE, row counter=0, valid_o=0, last_o=0, row_idx_o=0, row_o=0, ready_o=1 (evaluated after reset deasserts). Tile storage contents are don't-care. Reset mid-drain discards the tile; no further beats are emitted.
- Tile accept fires on valid_i && ready_o: all M*N words are captured in that cycle; row counter is cleared to 0.
- FSM, 2 states:
  - IDLE: ready_o=1, valid_o=0. On accept -> DRAIN.
  - DRAIN: ready_o=0, valid_o=1, row_o=buf[row_cnt], row_idx_o=row_cnt, last_o=(row_cnt==M-1).
    - On beat (valid_o && ready_i) with row_cnt<M-1: row_cnt++.
    - On beat with row_cnt==M-1: -> IDLE, row_cnt=0.
- Latency: row 0 is presented on the cycle after tile accept (1 cycle). No combinational path from valid_i to valid_o or from ready_i to ready_o.
- Single-buffer throughput: one tile per M+1 cycles when ready_i is held 1. ready_o stays 0 during the last beat.
- Output stability: while valid_o=1 && ready_i=0, row_o, row_idx_o and last_o hold stable. valid_o never drops without a beat.
- Data is passed through bit-exact: no truncation, no sign change, no reordering within a row. Element j of row_o equals D_i[row][j].
- D_i and valid_i are ignored whenever ready_o=0.
- M=1: every beat carries last_o=1.

Optional Feature:
SYN_TLE_DRAIN_DOUBLE_BUF_EN
- Defined: two tile slots with write pointer, read pointer and occupancy count (0..2).
  - ready_o=(count<2).
  - Accept writes slot[wr_ptr].
  - Drain reads slot[rd_ptr]; the last beat advances rd_ptr.
  - Simultaneous accept and last beat leave count unchanged.
  - After a last beat, the next tile's row 0 is presented the following cycle if count>0; valid_o is not deasserted in between.
  - Sustained throughput: one tile per M cycles.
  - Reset clears both pointers and count.
- Undefined: single-slot, 2-state FSM exactly as described in Behaviour.

Test Plan:
- Basic drain (M=8, N=4, P=8): D_i[r][c]=16*r+c, accept at cycle 0, ready_i=1 -> beats at cycles 1..8. Row r carries {16r, 16r+1, 16r+2, 16r+3}, row_idx_o=r; last_o=1 only at cycle 8. ready_o=1 again at cycle 9.
- Backpressure: ready_i=0 for cycles 3..6 during drain -> row_o, row_idx_o and last_o hold the cycle-3 values (row 2) throughout. No row is dropped or duplicated; 8 beats total.
- Signed extremes: D_i entries 32'h8000_0000 and 32'h7FFF_FFFF -> output bit-identical.
- Back-to-back tiles, valid_i held 1, ready_i=1:
  - Without macro: second tile accepted at cycle 9, its row 0 at cycle 10.
  - With macro: second tile accepted at cycle 1, its row 0 at cycle 9; valid_o stays high cycles 1..16; ready_o low while count==2.
- Reset mid-operation: assert rst_ni at row 3 of the drain -> valid_o=0, last_o=0, row_idx_o=0 immediately (async). After release, ready_o=1. A new tile D_i=all 5 drains as 8 rows of 5.
- Ignore while busy (no macro): pulse valid_i with D_i=all 7 during drain -> not captured; the current tile continues unchanged.
